// File: rtl/instr_prefetch_pkg.sv
// Shared types and bus constants for the instruction prefetcher.
// Bus access codes and the queue entry layout live here so top, FIFO and bench agree.
package instr_prefetch_pkg;

  localparam int BUS_WIDTH       = 32;
  localparam int BUS_ACC_WIDTH   = 2;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'b10;
  localparam int IPF_ENTRY_WIDTH = 65;

  // One queued fetch result: address, fetched word, and whether the bus rejected it.
  typedef struct packed {
    logic [31:0]          pc;
    logic [BUS_WIDTH-1:0] data;
    logic                 fault;
  } ipf_entry_t;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_PEND = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instr_prefetch_if.sv
// Instruction bus between the prefetcher (master) and memory (slave).
// Single-outstanding read bus: req strobe, fault same cycle, resp one or more cycles later.
interface instr_prefetch_if;
  import instr_prefetch_pkg::*;

  logic [31:0]              ibus_addr;
  logic                     ibus_w_rb;
  logic [BUS_ACC_WIDTH-1:0] ibus_acc;
  logic [BUS_WIDTH-1:0]     ibus_wdata;
  logic                     ibus_req;
  logic [BUS_WIDTH-1:0]     ibus_rdata;
  logic                     ibus_resp;
  logic                     ibus_fault;

  modport master (
    output ibus_addr, ibus_w_rb, ibus_acc, ibus_wdata, ibus_req,
    input  ibus_rdata, ibus_resp, ibus_fault
  );

  modport slave (
    input  ibus_addr, ibus_w_rb, ibus_acc, ibus_wdata, ibus_req,
    output ibus_rdata, ibus_resp, ibus_fault
  );

endinterface

// File: rtl/ipf_fifo.sv
// Synchronous FIFO with two ordered write ports (push before push2), pop and flush.
// Latency: write visible at head the cycle after push; no internal backpressure, caller guards count.
module ipf_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             push2,
  input  logic [WIDTH-1:0] push2_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    wr2_ptr;

  // The second write lands behind the first when both fire in one cycle.
  assign wr2_ptr  = wr_ptr + AW'(push);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  mem[wr_ptr]  <= push_dat;
      if (push2) mem[wr2_ptr] <= push2_dat;
      wr_ptr <= wr_ptr + AW'(push) + AW'(push2);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push) + CW'(push2) - CW'(pop);
    end
  end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: one outstanding bus read feeding a DEPTH-entry in-order queue.
// Latency flush->instr_valid 3 cycles on a 1-cycle bus; stops issuing when queue plus in-flight fill DEPTH.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  input  logic [31:0]         flush_pc,
  instr_prefetch_if.master    ibus,
  output logic [31:0]         instr,
  output logic [31:0]         instr_pc,
  output logic                instr_fault,
  output logic                instr_valid,
  input  logic                instr_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  fetch_state_e fs_q, fs_d;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  req_pc_q;
  logic         halt_q;
  logic [CW-1:0] count;
  logic [CW:0]  occ;
  logic         pend, drop, pop, issue, issue_ok, resp_push, fault_push;
  ipf_entry_t   head, resp_ent, fault_ent;

  assign pend = (fs_q != FS_IDLE);
  assign drop = (fs_q == FS_DROP);
  assign pop  = instr_valid & instr_ready;

  // Slots already claimed: queued entries plus the in-flight read, minus what leaves now.
  assign occ = {1'b0, count} + {{CW{1'b0}}, pend} - {{CW{1'b0}}, pop};

  assign issue = rstn & ~flush & ~halt_q & ~drop & (~pend | ibus.ibus_resp) & (occ < DEPTH_W);
  assign issue_ok   = issue & ~ibus.ibus_fault;
  assign fault_push = issue & ibus.ibus_fault;
  assign resp_push  = ibus.ibus_resp & pend & ~drop & ~flush;

  assign resp_ent  = '{pc: req_pc_q,   data: ibus.ibus_rdata, fault: 1'b0};
  assign fault_ent = '{pc: fetch_pc_q, data: '0,              fault: 1'b1};

  assign ibus.ibus_addr  = fetch_pc_q;
  assign ibus.ibus_req   = issue;
  assign ibus.ibus_w_rb  = 1'b0;
  assign ibus.ibus_acc   = BUS_ACC_4B;
  assign ibus.ibus_wdata = '0;

  always_comb begin
    fs_d = fs_q;
    case (fs_q)
      FS_IDLE: if (issue_ok) fs_d = FS_PEND;
      FS_PEND: begin
        if (flush)               fs_d = ibus.ibus_resp ? FS_IDLE : FS_DROP;
        else if (ibus.ibus_resp) fs_d = issue_ok ? FS_PEND : FS_IDLE;
      end
      FS_DROP: if (ibus.ibus_resp) fs_d = FS_IDLE;
      default: fs_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fs_q       <= FS_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      halt_q     <= 1'b0;
    end else begin
      fs_q <= fs_d;
      if (flush) begin
        fetch_pc_q <= flush_pc;
        halt_q     <= 1'b0;
      end else begin
        if (issue_ok) begin
          fetch_pc_q <= pc_next(fetch_pc_q);
          req_pc_q   <= fetch_pc_q;
        end
        if (fault_push) halt_q <= 1'b1;
      end
    end
  end

  ipf_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (IPF_ENTRY_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .push      (resp_push),
    .push_dat  (resp_ent),
    .push2     (fault_push),
    .push2_dat (fault_ent),
    .pop       (pop),
    .head_dat  (head),
    .count     (count)
  );

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? head.data  : '0;
  assign instr_pc    = instr_valid ? head.pc    : '0;
  assign instr_fault = instr_valid ? head.fault : 1'b0;

endmodule

// File: tb/tb_instr_prefetch.sv
// Randomized bench for instr_prefetch: queue-level reference model plus directed literal checks.
module tb_instr_prefetch;
  import instr_prefetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk, rstn, flush, instr_ready, instr_fault, instr_valid;
  logic [31:0] flush_pc, instr, instr_pc;

  instr_prefetch_if bus ();
  assign bus.ibus_fault = bus.ibus_req & (bus.ibus_addr[1:0] != 2'b00);

  instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .ibus        (bus),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_fault (instr_fault),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; logic fault; } ent_t;
  typedef struct { int due; logic [31:0] addr; } rsp_t;

  ent_t        mq[$];
  rsp_t        bq[$];
  logic [31:0] m_pc, m_out_addr;
  logic        m_out, m_drop, m_halt;
  int          n_chk = 0, n_fail = 0, cyc = 0, lat_min = 1, lat_max = 1;
  logic        o_req, o_valid, o_fault, o_bfault;
  logic [31:0] o_addr, o_pc, o_instr;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    bq.delete();
    m_pc = RESET_PC; m_out = 0; m_drop = 0; m_halt = 0; m_out_addr = '0;
  endtask

  // Reference: what the bus and head must show this cycle, then advance the queue model.
  task automatic model_step(input logic f, input logic [31:0] fpc, input logic rdy, input logic resp);
    logic pop, ereq;
    int   occ;
    pop  = (mq.size() > 0) && rdy;
    occ  = mq.size() + (m_out ? 1 : 0) - (pop ? 1 : 0);
    ereq = !f && !m_halt && !m_drop && (!m_out || resp) && (occ < DEPTH);
    chk("ibus_req", o_req, ereq);
    chk("ibus_addr", o_addr, m_pc);
    chk("ibus_ctl", {29'b0, bus.ibus_w_rb, bus.ibus_acc}, {29'b0, 1'b0, BUS_ACC_4B});
    chk("ibus_wdata", bus.ibus_wdata, 32'h0);
    chk("instr_valid", o_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("instr_pc", o_pc, mq[0].pc);
      chk("instr", o_instr, mq[0].data);
      chk("instr_fault", o_fault, mq[0].fault);
    end else begin
      chk("instr_pc_empty", o_pc, 32'h0);
      chk("instr_empty", {o_instr[31:1], o_instr[0] | o_fault}, 32'h0);
    end
    if (f) begin
      mq.delete();
      m_pc = fpc; m_halt = 0;
      if (m_out && !resp) m_drop = 1;
      else begin m_out = 0; m_drop = 0; end
    end else begin
      if (pop) void'(mq.pop_front());
      if (resp && m_out) begin
        if (!m_drop) mq.push_back('{m_out_addr, rom(m_out_addr), 1'b0});
        m_out = 0; m_drop = 0;
      end
      if (ereq) begin
        if (m_pc[1:0] != 2'b00) begin
          mq.push_back('{m_pc, 32'h0, 1'b1});
          m_halt = 1;
        end else begin
          m_out = 1; m_out_addr = m_pc; m_pc = m_pc + 32'd4;
        end
      end
    end
    if (mq.size() > DEPTH) chk("model_overflow", mq.size(), DEPTH);
  endtask

  // Called at posedge+1: drive this cycle's inputs, sample at negedge, return at next posedge+1.
  task automatic cycle(input logic f, input logic [31:0] fpc, input logic rdy);
    logic resp;
    flush = f; flush_pc = fpc; instr_ready = rdy;
    cyc++;
    resp = (bq.size() > 0) && (bq[0].due == cyc);
    bus.ibus_resp  = resp;
    bus.ibus_rdata = resp ? rom(bq[0].addr) : $urandom;
    @(negedge clk);
    o_req = bus.ibus_req; o_addr = bus.ibus_addr; o_bfault = bus.ibus_fault;
    o_valid = instr_valid; o_pc = instr_pc; o_instr = instr; o_fault = instr_fault;
    model_step(f, fpc, rdy, resp);
    if (resp) void'(bq.pop_front());
    if (o_req && !o_bfault) bq.push_back('{cyc + int'($urandom_range(lat_max, lat_min)), o_addr});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    flush = 0; instr_ready = 1; bus.ibus_resp = 0; bus.ibus_rdata = '0;
    #2 rstn = 0;
    #1;
    chk("rst_req", bus.ibus_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_fault", instr_fault, 1'b0);
    chk("rst_addr", bus.ibus_addr, RESET_PC);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] h_pc, h_instr, prev, r;
    logic        found;
    rstn = 1; flush = 0; flush_pc = '0; instr_ready = 0;
    bus.ibus_resp = 0; bus.ibus_rdata = '0;
    @(posedge clk); #1;
    do_reset();

    // Streaming from reset on a 1-cycle bus.
    for (int k = 0; k < 8; k++) begin
      cycle(0, 0, 1);
      if (k == 0) begin chk("first_req", o_req, 1'b1); chk("first_addr", o_addr, RESET_PC); end
      if (k == 1) chk("valid_c1", o_valid, 1'b0);
      if (k >= 2) begin
        chk("seq_pc", o_pc, 32'((k - 2) * 4));
        chk("seq_instr", o_instr, rom(32'((k - 2) * 4)));
        chk("seq_req", o_req, 1'b1);
      end
    end

    // Consumer stall: head holds, queue fills to DEPTH, then drains in order.
    cycle(0, 0, 0);
    h_pc = o_pc; h_instr = o_instr;
    for (int i = 1; i < 10; i++) begin
      cycle(0, 0, 0);
      chk("stall_head_pc", o_pc, h_pc);
      chk("stall_head_instr", o_instr, h_instr);
      if (i >= 6) chk("stall_no_req", o_req, 1'b0);
    end
    chk("stall_depth", mq.size(), DEPTH);
    prev = h_pc - 32'd4;
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 1);
      chk("drain_valid", o_valid, 1'b1);
      chk("drain_pc", o_pc, prev + 32'd4);
      prev = o_pc;
    end

    // Random traffic: variable bus latency, ready, flushes, occasional misaligned targets.
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      if ($urandom_range(0, 3) == 0) r = 32'hFFFF_FFE0 | (r & 32'h1C);
      r = ($urandom_range(0, 9) == 0) ? {r[31:2], 2'b10} : {r[31:2], 2'b00};
      cycle($urandom_range(0, 99) < 4, r, $urandom_range(0, 3) != 0);
    end

    // Flush over an outstanding 3-cycle read: stale data must not surface.
    lat_min = 3; lat_max = 3;
    cycle(1, 32'h1000, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bq.size() > 0 && bq[0].due > cyc + 1) found = 1;
      else cycle(0, 0, 1);
    end
    chk("pend_found", found, 1'b1);
    cycle(1, 32'h100, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(0, 0, 1);
      if (o_valid) begin
        found = 1;
        chk("flush_pc", o_pc, 32'h100);
        chk("flush_instr", o_instr, rom(32'h100));
      end
    end
    chk("flush_valid_seen", found, 1'b1);

    // Flush latency on a 1-cycle bus.
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 6; i++) cycle(0, 0, 1);
    cycle(1, 32'h200, 1);
    cycle(0, 0, 1); chk("lat_req", o_req, 1'b1); chk("lat_addr", o_addr, 32'h200);
    cycle(0, 0, 1); chk("lat_valid_t2", o_valid, 1'b0);
    cycle(0, 0, 1); chk("lat_valid_t3", o_valid, 1'b1); chk("lat_pc", o_pc, 32'h200);

    // Misaligned target faults once and halts fetching.
    cycle(1, 32'h102, 1);
    cycle(0, 0, 1); chk("mis_req", o_req, 1'b1); chk("mis_addr", o_addr, 32'h102);
    chk("mis_busfault", o_bfault, 1'b1);
    cycle(0, 0, 1); chk("mis_valid", o_valid, 1'b1); chk("mis_pc", o_pc, 32'h102);
    chk("mis_fault", o_fault, 1'b1); chk("mis_instr", o_instr, 32'h0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1);
      chk("halt_no_req", o_req, 1'b0);
      chk("halt_empty", o_valid, 1'b0);
    end

    // Address wrap at the top of the space.
    cycle(1, 32'hFFFF_FFFC, 1);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    cycle(0, 0, 1); chk("wrap_pc0", o_pc, 32'hFFFF_FFFC);
    cycle(0, 0, 1); chk("wrap_pc1", o_pc, 32'h0);

    // Reset with a read in flight.
    lat_min = 3; lat_max = 3;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(0, 0, 1);
      if (bq.size() > 0) found = 1;
    end
    chk("rst_pend_found", found, 1'b1);
    do_reset();
    cycle(0, 0, 1); chk("post_rst_req", o_req, 1'b1); chk("post_rst_addr", o_addr, RESET_PC);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(0, 0, 1);
      if (o_valid) begin found = 1; chk("post_rst_pc", o_pc, RESET_PC); end
    end
    chk("post_rst_valid_seen", found, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Parameter DEPTH, default 2, queue entries (power of two, 2..8).
REQ-002 Parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 flush  in  1  redirect request, one-cycle pulse.
REQ-006 flush_pc  in  32  new fetch address.
REQ-007 ibus_addr  out  32  fetch address.
REQ-008 ibus_w_rb  out  1  tied 0 (read only).
REQ-009 ibus_acc  out  `BUS_ACC_WIDTH  tied `BUS_ACC_4B.
REQ-010 ibus_wdata  out  `BUS_WIDTH  tied 0.
REQ-011 ibus_req  out  1  one-cycle request strobe.
REQ-012 ibus_rdata  in  `BUS_WIDTH  read data, valid with ibus_resp.
REQ-013 ibus_resp  in  1  response, one or more cycles after ibus_req.
REQ-014 ibus_fault  in  1  rejection, same cycle as ibus_req.
REQ-015 instr  out  32  head instruction word.
REQ-016 instr_pc  out  32  head instruction address.
REQ-017 instr_fault  out  1  head entry is a fetch fault.
REQ-018 instr_valid  out  1  head entry present.
REQ-019 instr_ready  in  1  consumer accepts head.

Function
REQ-020 State: fetch_pc, count_q (0..DEPTH), pend_q (one request outstanding), drop_q (outstanding response to discard), halt_q (fault seen).
REQ-021 Issue condition: ~flush & ~halt_q & ~drop_q & (~pend_q | ibus_resp) & (count_q + pend_q - pop < DEPTH), pop = instr_valid & instr_ready; ibus_req equals it.
REQ-022 ibus_addr = fetch_pc whenever ibus_req is high; otherwise fetch_pc as well.
REQ-023 Issue without fault: pend_q set, fetch_pc += 4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-024 Issue with ibus_fault: pend_q not set, entry {fetch_pc, 32'h0, fault=1} pushed at that edge, halt_q set, fetch_pc unchanged.
REQ-025 ibus_resp with pend_q & ~drop_q & ~flush: entry {address of request, ibus_rdata, fault=0} pushed; pend_q cleared unless a new issue occurs in the same cycle.
REQ-026 ibus_resp with drop_q: data discarded, drop_q and pend_q cleared.
REQ-027 Queue FIFO-ordered; simultaneous push and pop leaves count_q unchanged; pop on empty impossible (instr_valid low).
REQ-028 instr_valid = (count_q != 0); instr/instr_pc/instr_fault show head entry, 0 when empty.
REQ-029 Head SHALL stay stable while instr_valid & ~instr_ready.
REQ-030 flush has priority over every push, pop and issue in its cycle: queue emptied, fetch_pc = flush_pc, halt_q cleared.
REQ-031 flush while pend_q & ~ibus_resp: drop_q set; flush coincident with ibus_resp: response discarded, drop_q stays 0.
REQ-032 Latency with 1-cycle bus: flush in cycle T -> ibus_req in T+1 with flush_pc -> ibus_resp T+2 -> instr_valid T+3.
REQ-033 Steady state with 1-cycle bus and instr_ready high: one ibus_req and one instr per cycle.
REQ-034 Misaligned flush_pc is issued unchanged; the bus fault path reports it.

Reset
REQ-035 rstn low: fetch_pc = RESET_PC, count_q = pend_q = drop_q = halt_q = 0, queue storage 0, ibus_req = 0, instr_valid = 0, all instr outputs 0.
REQ-036 Reset mid-transaction abandons any outstanding request; a late ibus_resp after reset release with pend_q = 0 is ignored.
REQ-037 First ibus_req in the first clock cycle after rstn deasserts.

Structure
REQ-038 `IPF_ENTRY_WIDTH (65 = pc + data + fault) defined in femto.vh beside the bus constants; BUS_ACC codes reused from there.
REQ-039 Storage in one sub-module ipf_fifo (synchronous FIFO, DEPTH and width parameters, async active-low reset, push/pop/flush/count).

Verification
REQ-040 Reset release, 1-cycle ROM model, instr_ready=1 -> instr_pc 0,4,8,... on consecutive cycles, instr = ROM words.
REQ-041 instr_ready=0 for 10 cycles -> exactly DEPTH entries held, no ibus_req while full, head stable; ready=1 -> resumes without loss or duplication.
REQ-042 flush (flush_pc=32'h100) while pend_q with 3-cycle bus -> stale response discarded, next instr_pc = 32'h100.
REQ-043 flush_pc=32'h102 -> ibus_fault -> single entry fault=1, instr_pc=32'h102, no further ibus_req until next flush.
REQ-044 flush_pc=32'hFFFF_FFFC -> instr_pc FFFF_FFFC then 0.
REQ-045 rstn asserted with request outstanding -> all outputs 0 immediately; first post-reset instr_pc = RESET_PC.
